button_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the digital watch core.
- Takes the five raw, bouncing pushbuttons (mode, set, op1, op2, free) and produces the clean single-cycle command pulses u_mode, u_set, u_op1, u_op2, u_free that the watch consumes.
- Per button: 2-flop synchronisation and counter-based debounce, then rising-edge one-pulse generation.
- op1/op2 also auto-repeat while held, for fast time/alarm adjustment in set mode.

---
 rtl/button_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front end for the watch core.
// Each raw pushbutton goes through a 2-flop synchroniser and a counter debounce.
// A one-cycle command pulse follows each accepted press.
// op1/op2 also auto-repeat while held and rep_en is high.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_op1,
    input  logic       btn_op2,
    input  logic       btn_free,
    input  logic       rep_en,
    output logic       u_mode,
    output logic       u_set,
    output logic       u_op1,
    output logic       u_op2,
    output logic       u_free,
    output logic [4:0] held
);

    localparam int NB      = 5;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W    = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
    localparam logic [RC_W-1:0]  RC_ONE      = RC_W'(1);

    // Bit positions inside the button vector; op1/op2 are the repeating ones.
    localparam int IDX_OP1 = 2;
    localparam int IDX_OP2 = 3;

    // Auto-repeat phase: waiting for the long first delay, or in the fast cadence.
    typedef enum logic {
        WAIT_FIRST = 1'b0,
        REPEATING  = 1'b1
    } rep_phase_e;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] pulse_vec;

    assign btn_raw = {btn_free, btn_op2, btn_op1, btn_set, btn_mode};

    assign u_mode = pulse_vec[0];
    assign u_set  = pulse_vec[1];
    assign u_op1  = pulse_vec[2];
    assign u_op2  = pulse_vec[3];
    assign u_free = pulse_vec[4];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             stable_q;
            logic             stable_d;
            logic             stable_dly_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             press;
            logic             repeat_fire;
            logic             pulse_q;
            logic             pulse_d;

            // Two-flop synchroniser for the asynchronous raw button.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Debounce: a new level is accepted only after it disagrees with the
            // current one for DEBOUNCE_CYCLES consecutive cycles; any agreement
            // restarts the count.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync2_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Debounce state, plus a delayed copy of the level for edge detection.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    stable_q     <= 1'b0;
                    stable_dly_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    stable_q     <= stable_d;
                    stable_dly_q <= stable_q;
                    cnt_q        <= cnt_d;
                end
            end

            // Rising edge of the debounced level is the press event; release is ignored.
            assign press = stable_q & ~stable_dly_q;

            if (gi == IDX_OP1 || gi == IDX_OP2) begin : g_rep
                rep_phase_e      phase_q;
                rep_phase_e      phase_d;
                logic [RC_W-1:0] rc_q;
                logic [RC_W-1:0] rc_d;
                logic            fire_d;

                // Repeat timer: counts only while held with repeat enabled. The press
                // event restarts it, so a repeat never lands on the press pulse.
                always_comb begin
                    phase_d = phase_q;
                    rc_d    = rc_q;
                    fire_d  = 1'b0;
                    if (!stable_q || !rep_en || press) begin
                        phase_d = WAIT_FIRST;
                        rc_d    = '0;
                    end else begin
                        case (phase_q)
                            WAIT_FIRST: begin
                                if (rc_q == DELAY_LAST) begin
                                    fire_d  = 1'b1;
                                    rc_d    = '0;
                                    phase_d = REPEATING;
                                end else begin
                                    rc_d = rc_q + RC_ONE;
                                end
                            end
                            REPEATING: begin
                                if (rc_q == PERIOD_LAST) begin
                                    fire_d = 1'b1;
                                    rc_d   = '0;
                                end else begin
                                    rc_d = rc_q + RC_ONE;
                                end
                            end
                            default: begin
                                phase_d = WAIT_FIRST;
                                rc_d    = '0;
                            end
                        endcase
                    end
                end

                // Repeat phase and timer registers.
                always_ff @(posedge clk_50MHz or negedge reset) begin
                    if (!reset) begin
                        phase_q <= WAIT_FIRST;
                        rc_q    <= '0;
                    end else begin
                        phase_q <= phase_d;
                        rc_q    <= rc_d;
                    end
                end

                assign repeat_fire = fire_d;
            end else begin : g_norep
                assign repeat_fire = 1'b0;
            end

            assign pulse_d = press | repeat_fire;

            // Registered single-cycle command pulse.
            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    pulse_q <= 1'b0;
                end else begin
                    pulse_q <= pulse_d;
                end
            end

            assign pulse_vec[gi] = pulse_q;
            assign held[gi]      = stable_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters.
// Tick j counts edges after the stimulus change, so a clean press shows
// held at tick 6 and the pulse at tick 7.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_set, btn_op1, btn_op2, btn_free, rep_en;
    logic       u_mode, u_set, u_op1, u_op2, u_free;
    logic [4:0] held;
    logic [4:0] u_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign u_vec = {u_free, u_op2, u_op1, u_set, u_mode};

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_50MHz(clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_set  (btn_set),
        .btn_op1  (btn_op1),
        .btn_op2  (btn_op2),
        .btn_free (btn_free),
        .rep_en   (rep_en),
        .u_mode   (u_mode),
        .u_set    (u_set),
        .u_op1    (u_op1),
        .u_op2    (u_op2),
        .u_free   (u_free),
        .held     (held)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (u_vec !== 5'b0 || held !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: u=%b held=%b expected 00000/00000", u_vec, held);
        end
        btn_set = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            checks++;
            if (u_vec !== 5'b0 || held !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold tick %0d: u=%b held=%b expected 00000/00000", j, u_vec, held);
            end
        end
        btn_set = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            checks++;
            if (u_vec !== 5'b0 || held !== 5'b0) begin
                errors++;
                $display("FAIL reset_release tick %0d: u=%b held=%b expected 00000/00000", j, u_vec, held);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_press();
        logic [4:0] exp_u, exp_h;
        btn_set = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            tick();
            exp_u = (j == 7) ? 5'b00010 : 5'b00000;
            exp_h = (j >= 6) ? 5'b00010 : 5'b00000;
            checks++;
            if (u_vec !== exp_u || held !== exp_h) begin
                errors++;
                $display("FAIL clean_press tick %0d: u=%b held=%b expected %b/%b", j, u_vec, held, exp_u, exp_h);
            end
        end
        btn_set = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            exp_h = (j < 6) ? 5'b00010 : 5'b00000;
            checks++;
            if (u_vec !== 5'b0 || held !== exp_h) begin
                errors++;
                $display("FAIL clean_release tick %0d: u=%b held=%b expected 00000/%b", j, u_vec, held, exp_h);
            end
        end
        $display("test_clean_press done");
    endtask

    task automatic test_bounce();
        logic [4:0] exp_u, exp_h;
        for (int ph = 0; ph < 4; ph++) begin
            btn_mode = (ph % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 1; j <= 2; j++) begin
                tick();
                checks++;
                if (u_vec !== 5'b0 || held !== 5'b0) begin
                    errors++;
                    $display("FAIL bounce phase %0d tick %0d: u=%b held=%b expected 00000/00000", ph, j, u_vec, held);
                end
            end
        end
        btn_mode = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            exp_u = (j == 7) ? 5'b00001 : 5'b00000;
            exp_h = (j >= 6) ? 5'b00001 : 5'b00000;
            checks++;
            if (u_vec !== exp_u || held !== exp_h) begin
                errors++;
                $display("FAIL bounce_settle tick %0d: u=%b held=%b expected %b/%b", j, u_vec, held, exp_u, exp_h);
            end
        end
        btn_mode = 1'b0;
        idle(12);
        $display("test_bounce done");
    endtask

    task automatic test_glitch();
        logic [4:0] exp_u, exp_h;
        // Three-cycle glitch is one short of the debounce window and is ignored.
        for (int j = 1; j <= 20; j++) begin
            btn_free = (j <= 3) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (u_vec !== 5'b0 || held !== 5'b0) begin
                errors++;
                $display("FAIL glitch_short tick %0d: u=%b held=%b expected 00000/00000", j, u_vec, held);
            end
        end
        // Four-cycle pulse exactly meets the window: accepted, then released.
        for (int j = 1; j <= 20; j++) begin
            btn_free = (j <= 4) ? 1'b1 : 1'b0;
            tick();
            exp_u = (j == 7) ? 5'b10000 : 5'b00000;
            exp_h = (j >= 6 && j <= 9) ? 5'b10000 : 5'b00000;
            checks++;
            if (u_vec !== exp_u || held !== exp_h) begin
                errors++;
                $display("FAIL glitch_exact tick %0d: u=%b held=%b expected %b/%b", j, u_vec, held, exp_u, exp_h);
            end
        end
        btn_free = 1'b0;
        idle(5);
        $display("test_glitch done");
    endtask

    task automatic test_repeat(input logic en);
        logic exp_p, exp_h;
        rep_en  = en;
        btn_op1 = 1'b1;
        for (int j = 1; j <= 85; j++) begin
            tick();
            if (en)
                exp_p = (j == 7 || j == 27 || j == 35 || j == 43 || j == 51 || j == 59);
            else
                exp_p = (j == 7);
            exp_h = (j >= 6 && j <= 65);
            checks++;
            if (u_vec !== {2'b00, exp_p, 2'b00} || held[2] !== exp_h) begin
                errors++;
                $display("FAIL repeat(en=%0b) tick %0d: u=%b held[2]=%b expected %b/%b", en, j, u_vec, held[2], {2'b00, exp_p, 2'b00}, exp_h);
            end
            if (j == 60) btn_op1 = 1'b0;
        end
        rep_en = 1'b0;
        $display("test_repeat en=%0b done", en);
    endtask

    task automatic test_rep_en_drop();
        logic exp_p;
        rep_en  = 1'b1;
        btn_op2 = 1'b1;
        for (int j = 1; j <= 75; j++) begin
            tick();
            exp_p = (j == 7 || j == 27 || j == 57);
            checks++;
            if (u_vec !== {1'b0, exp_p, 3'b000}) begin
                errors++;
                $display("FAIL rep_en_drop tick %0d: u=%b expected %b", j, u_vec, {1'b0, exp_p, 3'b000});
            end
            if (j == 32) rep_en = 1'b0;
            if (j == 37) rep_en = 1'b1;
            if (j == 58) btn_op2 = 1'b0;
        end
        rep_en = 1'b0;
        $display("test_rep_en_drop done");
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_u;
        rep_en  = 1'b0;
        btn_op1 = 1'b1;
        btn_op2 = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            tick();
            exp_u = (j == 7) ? 5'b01100 : 5'b00000;
            checks++;
            if (u_vec !== exp_u) begin
                errors++;
                $display("FAIL simultaneous tick %0d: u=%b expected %b", j, u_vec, exp_u);
            end
        end
        btn_op1 = 1'b0;
        btn_op2 = 1'b0;
        idle(12);
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        logic exp_p;
        rep_en  = 1'b1;
        btn_op1 = 1'b1;
        for (int j = 1; j <= 35; j++) begin
            tick();
            exp_p = (j == 7 || j == 27 || j == 35);
            checks++;
            if (u_vec !== {2'b00, exp_p, 2'b00}) begin
                errors++;
                $display("FAIL reset_mid_pre tick %0d: u=%b expected %b", j, u_vec, {2'b00, exp_p, 2'b00});
            end
        end
        // Assert reset while the repeat pulse is high; outputs must drop at once.
        reset = 1'b0;
        #1;
        checks++;
        if (u_vec !== 5'b0 || held !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_async: u=%b held=%b expected 00000/00000", u_vec, held);
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if (u_vec !== 5'b0 || held !== 5'b0) begin
                errors++;
                $display("FAIL reset_mid_hold tick %0d: u=%b held=%b expected 00000/00000", j, u_vec, held);
            end
        end
        reset = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            exp_p = (j == 7 || j == 27 || j == 35);
            checks++;
            if (u_vec !== {2'b00, exp_p, 2'b00} || held !== {2'b00, (j >= 6), 2'b00}) begin
                errors++;
                $display("FAIL reset_mid_post tick %0d: u=%b held=%b expected %b/%b", j, u_vec, held, {2'b00, exp_p, 2'b00}, {2'b00, (j >= 6), 2'b00});
            end
        end
        btn_op1 = 1'b0;
        rep_en  = 1'b0;
        idle(12);
        $display("test_reset_mid done");
    endtask

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        btn_op1  = 1'b0;
        btn_op2  = 1'b0;
        btn_free = 1'b0;
        rep_en   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_repeat(1'b1);
        test_repeat(1'b0);
        test_rep_en_drop();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
